// File: rtl/fib_engine.sv
`default_nettype none
// ============================================================================
//  Module      : fib_engine
//  Description : Emits the first n terms of a Fibonacci (0,1) or Lucas (2,1)
//                sequence, one term per cycle. The sequence stops early,
//                with a sticky overflow flag, rather than emit a term that
//                does not fit in WIDTH bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module fib_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n,
    input  logic             mode,
    output logic             busy,
    output logic             term_valid,
    output logic [WIDTH-1:0] term,
    output logic [CNT_W-1:0] term_idx,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_seed0_fib   = '0;
    localparam logic [WIDTH-1:0] c_seed0_lucas = WIDTH'(2);
    localparam logic [WIDTH-1:0] c_seed1       = WIDTH'(1);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             mode_q, mode_d;
    logic             a_bad_q, a_bad_d;
    logic             b_bad_q, b_bad_d;
    logic             term_valid_q, term_valid_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic [CNT_W-1:0] term_idx_q, term_idx_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;

    // One extra bit keeps the carry-out that marks B as no longer exact.
    logic [WIDTH:0]   sum_w;
    assign sum_w = {1'b0, a_q} + {1'b0, b_q};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath/output next values.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        idx_d        = idx_q;
        n_d          = n_q;
        mode_d       = mode_q;
        a_bad_d      = a_bad_q;
        b_bad_d      = b_bad_q;
        term_valid_d = 1'b0;
        term_d       = term_q;
        term_idx_d   = term_idx_q;
        done_d       = 1'b0;
        overflow_d   = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d        = n;
                    mode_d     = mode;
                    overflow_d = 1'b0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                a_d     = mode_q ? c_seed0_lucas : c_seed0_fib;
                b_d     = c_seed1;
                idx_d   = '0;
                a_bad_d = 1'b0;
                b_bad_d = 1'b0;
                state_d = (n_q == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (a_bad_q) begin
                    // A is the wrapped sum: truncate instead of emitting it.
                    overflow_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    term_valid_d = 1'b1;
                    term_d       = a_q;
                    term_idx_d   = idx_q;
                    a_d          = b_q;
                    b_d          = sum_w[WIDTH-1:0];
                    idx_d        = idx_q + c_one;
                    a_bad_d      = b_bad_q;
                    b_bad_d      = b_bad_q | sum_w[WIDTH];
                    if (idx_q == (n_q - c_one)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            idx_q        <= '0;
            n_q          <= '0;
            mode_q       <= 1'b0;
            a_bad_q      <= 1'b0;
            b_bad_q      <= 1'b0;
            term_valid_q <= 1'b0;
            term_q       <= '0;
            term_idx_q   <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            mode_q       <= mode_d;
            a_bad_q      <= a_bad_d;
            b_bad_q      <= b_bad_d;
            term_valid_q <= term_valid_d;
            term_q       <= term_d;
            term_idx_q   <= term_idx_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign term_valid = term_valid_q;
    assign term       = term_q;
    assign term_idx   = term_idx_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fib_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fib_engine
//  Description : Directed self-checking bench for fib_engine (WIDTH=8,
//                CNT_W=5) with hand-computed expected terms and timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_engine;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] n;
    logic       mode;
    logic       busy;
    logic       term_valid;
    logic [7:0] term;
    logic [4:0] term_idx;
    logic       done;
    logic       overflow;

    int vectors;
    int miscompares;

    int fib_tab[0:13]  = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    int lucas_tab[0:4] = '{2, 1, 3, 4, 7};

    fib_engine #(
        .WIDTH (8),
        .CNT_W (5)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n          (n),
        .mode       (mode),
        .busy       (busy),
        .term_valid (term_valid),
        .term       (term),
        .term_idx   (term_idx),
        .done       (done),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Starts a sequence from the current point (#1 after a rising edge) and
    // follows it to its done pulse, checking each term and its timing.
    task automatic run_seq(input string tag, input int nn, input logic md,
                           input int nexp, input int done_at, input logic ovf_exp,
                           input bit pulse_mid);
        int  cnt;
        int  done_c;
        int  exp_term;
        bit  busy_ok;
        bit  terms_ok;
        start = 1'b1;
        n     = 5'(nn);
        mode  = md;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        cnt      = 0;
        done_c   = -1;
        busy_ok  = 1'b1;
        terms_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) check({tag, " overflow_cleared"}, 32'(overflow), 32'd0);
            if (term_valid) begin
                exp_term = md ? ((cnt < 5) ? lucas_tab[cnt] : -1)
                              : ((cnt < 14) ? fib_tab[cnt] : -1);
                if (32'(term) !== 32'(exp_term) || 32'(term_idx) !== 32'(cnt) ||
                    c != cnt + 2) begin
                    terms_ok = 1'b0;
                    $display("FAIL %s term: cycle %0d term %0d idx %0d, expected term %0d idx %0d at cycle %0d",
                             tag, c, term, term_idx, exp_term, cnt, cnt + 2);
                end
                cnt++;
            end
            if (done) begin
                done_c = c;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (pulse_mid && c == 4) begin
                start = 1'b1;
                n     = 5'd3;
                mode  = 1'b1;
            end
            if (pulse_mid && c == 5) start = 1'b0;
        end
        check({tag, " terms_ok"},   32'(terms_ok), 32'd1);
        check({tag, " term_count"}, 32'(cnt),      32'(nexp));
        check({tag, " done_cycle"}, 32'(done_c),   32'(done_at));
        check({tag, " busy_held"},  32'(busy_ok),  32'd1);
        check({tag, " overflow"},   32'(overflow), 32'(ovf_exp));
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " idle_busy"},      32'(busy), 32'd0);
        check({tag, " overflow_held"},  32'(overflow), 32'(ovf_exp));
        if (nexp > 0) begin
            exp_term = md ? lucas_tab[nexp-1] : fib_tab[nexp-1];
            check({tag, " term_hold"},     32'(term),     32'(exp_term));
            check({tag, " term_idx_hold"}, 32'(term_idx), 32'(nexp - 1));
        end
    endtask

    initial begin
        int  seen;
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        n     = 5'd0;
        mode  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",       32'(busy),       32'd0);
        check("reset term_valid", 32'(term_valid), 32'd0);
        check("reset term",       32'(term),       32'd0);
        check("reset term_idx",   32'(term_idx),   32'd0);
        check("reset done",       32'(done),       32'd0);
        check("reset overflow",   32'(overflow),   32'd0);
        rst_n = 1'b1;

        run_seq("fib7",   7,  1'b0, 7,  9,  1'b0, 1'b0);
        run_seq("lucas5", 5,  1'b1, 5,  7,  1'b0, 1'b0);
        run_seq("n0",     0,  1'b0, 0,  2,  1'b0, 1'b0);
        run_seq("fib14",  14, 1'b0, 14, 16, 1'b0, 1'b0);
        run_seq("fib20",  20, 1'b0, 14, 17, 1'b1, 1'b0);

        // Overflow stays set while idle; the next run clears it on acceptance.
        repeat (3) @(posedge clk);
        #1;
        check("ovf sticky idle", 32'(overflow), 32'd1);
        run_seq("fib3_after_ovf", 3, 1'b0, 3, 5, 1'b0, 1'b0);

        run_seq("start_in_run", 7, 1'b0, 7, 9, 1'b0, 1'b1);

        // Abort mid-sequence with a one-edge reset once idx 3 is on the output.
        start = 1'b1;
        n     = 5'd7;
        mode  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        seen  = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (term_valid && term_idx == 5'd3) begin
                seen = 1;
                break;
            end
        end
        check("abort reached idx3", 32'(seen), 32'd1);
        check("abort term at idx3", 32'(term), 32'd2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort busy",       32'(busy),       32'd0);
        check("abort term_valid", 32'(term_valid), 32'd0);
        check("abort term",       32'(term),       32'd0);
        check("abort term_idx",   32'(term_idx),   32'd0);
        check("abort done",       32'(done),       32'd0);
        check("abort overflow",   32'(overflow),   32'd0);
        run_seq("after_abort", 7, 1'b0, 7, 9, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fib_engine.md
FIB_ENGINE -- requirements
Module: fib_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the term/datapath width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 5, giving the width of the term-count and term-index fields.
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n SHALL be input, 1 bit: reset, synchronous and active-low.
REQ-005 Port start SHALL be input, 1 bit: request to begin a sequence.
REQ-006 Port n SHALL be input, CNT_W bits: number of terms requested, sampled with start.
REQ-007 Port mode SHALL be input, 1 bit: seed select, 0 = Fibonacci (0,1), 1 = Lucas (2,1), sampled with start.
REQ-008 Port busy SHALL be output, 1 bit: high in every state other than IDLE.
REQ-009 Port term_valid SHALL be output, 1 bit: high for one cycle per emitted term.
REQ-010 Port term SHALL be output, WIDTH bits: the emitted term value.
REQ-011 Port term_idx SHALL be output, CNT_W bits: index k of the emitted term.
REQ-012 Port done SHALL be output, 1 bit: one-cycle completion pulse.
REQ-013 Port overflow SHALL be output, 1 bit: sticky flag, set when the sequence was truncated.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, RUN and DONE.
REQ-015 In IDLE, start=1 SHALL latch n and mode, clear overflow and move to LOAD.
REQ-016 start SHALL be ignored in every state other than IDLE.
REQ-017 LOAD SHALL set A = seed0 (0 or 2), B = seed1 (1), idx = 0 and bad flags = 0.
REQ-018 LOAD SHALL go to DONE when the latched n = 0, otherwise to RUN.
REQ-019 Each RUN cycle with a_bad = 0 SHALL assert term_valid with term = A and term_idx = idx.
REQ-020 The same RUN cycle SHALL update A <= B, B <= (A+B) mod 2^WIDTH and idx <= idx+1.
REQ-021 In RUN, a_bad <= b_bad and b_bad <= b_bad | carry-out of A+B.
REQ-022 RUN SHALL go to DONE after emitting the term with idx = n-1.
REQ-023 A RUN cycle with a_bad = 1 SHALL emit nothing, set overflow and go to DONE; no truncated value is ever emitted.
REQ-024 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-025 Latency: first term_valid SHALL occur 2 cycles after the start-sampling edge.
REQ-026 Terms SHALL be emitted back-to-back, one per cycle, with no gaps.
REQ-027 For n >= 1 without overflow, done SHALL occur n+2 cycles after the start edge.
REQ-028 term and term_idx SHALL hold their last values when term_valid = 0.
REQ-029 overflow SHALL hold until the next accepted start or reset.
REQ-030 All arithmetic SHALL be unsigned WIDTH-bit.
REQ-031 idx SHALL never wrap, because n <= 2^CNT_W - 1.

Reset
REQ-032 While rst_n = 0 at a clock edge, the FSM SHALL enter IDLE.
REQ-033 The same edge SHALL clear busy, term_valid, done, overflow, term, term_idx, A, B, idx and the bad flags to 0.
REQ-034 Reset asserted mid-sequence SHALL abort without a done pulse.
REQ-035 The first start after reset SHALL be accepted on the cycle after rst_n returns to 1.

Verification (WIDTH=8, CNT_W=5)
REQ-036 start, n=7, mode=0 -> terms 0,1,1,2,3,5,8 at idx 0..6; done 9 cycles after start; overflow=0.
REQ-037 start, n=5, mode=1 -> terms 2,1,3,4,7; overflow=0.
REQ-038 start, n=0 -> no term_valid; done pulse 2 cycles after start; busy high for exactly 2 cycles.
REQ-039 start, n=14, mode=0 -> 14 terms, last = 233 at idx 13; overflow=0.
REQ-040 start, n=20, mode=0 -> 14 terms ending 233, then done with overflow=1; overflow stays 1 until the next start.
REQ-041 start pulsed during RUN -> ignored, sequence unchanged.
REQ-042 rst_n=0 for one edge at idx 3 -> outputs and busy become 0, no done pulse; a new start then gives a clean sequence.
